// File: rtl/roberts_mdc_tcdm_rr_arbiter.sv
// Round-robin arbiter that shares one TCDM master port among N_REQ requesters and routes responses via an in-order ID FIFO.
// Latency: request/payload/grant are combinational (zero cycles); responses are routed combinationally to the issuer.
// Backpressure: a stalled TCDM grant locks the winner; a full ID FIFO (MAX_OUT outstanding) blocks new requests until the cycle after a pop.
// Optional feature: define ROBERTS_MDC_TCDM_ARB_PERF_CNT_EN to add saturating grant/stall performance counters.
module roberts_mdc_tcdm_rr_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned MAX_OUT = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic [N_REQ-1:0]      in_req_i,
   output logic [N_REQ-1:0]      in_gnt_o,
   input  logic [N_REQ*AW-1:0]   in_add_i,
   input  logic [N_REQ-1:0]      in_wen_i,
   input  logic [N_REQ*DW/8-1:0] in_be_i,
   input  logic [N_REQ*DW-1:0]   in_data_i,
   output logic [DW-1:0]         in_r_data_o,
   output logic [N_REQ-1:0]      in_r_valid_o,
   output logic                  tcdm_req_o,
   input  logic                  tcdm_gnt_i,
   output logic [AW-1:0]         tcdm_add_o,
   output logic                  tcdm_wen_o,
   output logic [DW/8-1:0]       tcdm_be_o,
   output logic [DW-1:0]         tcdm_data_o,
   input  logic [DW-1:0]         tcdm_r_data_i,
   input  logic                  tcdm_r_valid_i,
   output logic                  err_o
`ifdef ROBERTS_MDC_TCDM_ARB_PERF_CNT_EN
   ,
   output logic [31:0]           perf_gnt_cnt_o,
   output logic [31:0]           perf_stall_cnt_o
`endif
);

   localparam int unsigned BW  = DW / 8;
   localparam int unsigned IDW = $clog2(N_REQ);
   localparam int unsigned FAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   typedef enum logic {ARB, LOCKED} state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   ptr, ptr_nxt, lock_id, rr_win, win, head;
   logic [IDW:0]     sum, win_inc;
   logic             found, any_req, full, empty, req, push, pop;
   logic [IDW-1:0]   fifo_mem [MAX_OUT];
   logic [FAW-1:0]   wr_idx, rd_idx;
   logic [FAW:0]     count;

   assign any_req = |in_req_i;
   assign full    = (count == (FAW+1)'(MAX_OUT));
   assign empty   = (count == '0);
   assign head    = fifo_mem[rd_idx];
   assign pop     = tcdm_r_valid_i & ~empty;

   // Cyclic priority search: first asserted request at or after the pointer.
   always_comb begin
      rr_win = ptr;
      found  = 1'b0;
      sum    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sum = {1'b0, ptr} + (IDW+1)'(i);
         if (sum >= (IDW+1)'(N_REQ)) sum = sum - (IDW+1)'(N_REQ);
         if (!found && in_req_i[sum[IDW-1:0]]) begin
            rr_win = sum[IDW-1:0];
            found  = 1'b1;
         end
      end
   end

   // FSM next state, request/grant generation and payload mux from the current winner.
   always_comb begin
      state_nxt = state;
      win       = (state == LOCKED) ? lock_id : rr_win;
      // Reset and soft clear both silence the master port immediately.
      req       = rst_ni & ~clear_i & ((state == LOCKED) | (any_req & ~full));
      push      = req & tcdm_gnt_i;
      if (req && !tcdm_gnt_i) state_nxt = LOCKED;
      else if (push)          state_nxt = ARB;
      win_inc = {1'b0, win} + (IDW+1)'(1);
      ptr_nxt = (win_inc == (IDW+1)'(N_REQ)) ? '0 : win_inc[IDW-1:0];
      in_gnt_o    = push ? (N_REQ'(1) << win) : '0;
      tcdm_req_o  = req;
      tcdm_add_o  = req ? in_add_i[int'(win)*AW +: AW] : '0;
      tcdm_wen_o  = req ? in_wen_i[win] : 1'b0;
      tcdm_be_o   = req ? in_be_i[int'(win)*BW +: BW] : '0;
      tcdm_data_o = req ? in_data_i[int'(win)*DW +: DW] : '0;
      in_r_valid_o = pop ? (N_REQ'(1) << head) : '0;
      in_r_data_o  = tcdm_r_data_i;
   end

   // State register, round-robin pointer and locked winner ID.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= ARB;
         ptr     <= '0;
         lock_id <= '0;
      end else if (clear_i) begin
         state   <= ARB;
         ptr     <= '0;
         lock_id <= '0;
      end else begin
         state <= state_nxt;
         if (push) ptr <= ptr_nxt;
         if (state == ARB && req && !tcdm_gnt_i) lock_id <= win;
      end
   end

   // ID FIFO pointers and occupancy; push on grant, pop on response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
      end else if (clear_i) begin
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
      end else begin
         if (push) wr_idx <= wr_idx + FAW'(1);
         if (pop)  rd_idx <= rd_idx + FAW'(1);
         if (push && !pop)      count <= count + (FAW+1)'(1);
         else if (!push && pop) count <= count - (FAW+1)'(1);
      end
   end

   // ID FIFO storage; contents are only meaningful between push and pop.
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_idx] <= win;
   end

   // Sticky error: a response arrived with nothing outstanding.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                          err_o <= 1'b0;
      else if (clear_i)                     err_o <= 1'b0;
      else if (tcdm_r_valid_i && empty)     err_o <= 1'b1;
   end

`ifdef ROBERTS_MDC_TCDM_ARB_PERF_CNT_EN
   // Saturating counters for granted transactions and stalled request cycles.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_gnt_cnt_o   <= '0;
         perf_stall_cnt_o <= '0;
      end else if (clear_i) begin
         perf_gnt_cnt_o   <= '0;
         perf_stall_cnt_o <= '0;
      end else begin
         if (push && perf_gnt_cnt_o != '1) perf_gnt_cnt_o <= perf_gnt_cnt_o + 32'd1;
         if (any_req && !push && perf_stall_cnt_o != '1) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_roberts_mdc_tcdm_rr_arbiter.sv
// Directed bench for the TCDM round-robin arbiter with grant/response scoreboard queues.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle or at the falling edge.
// Expected grants are queued by the stimulus; responses are expected in grant order.
module tb_roberts_mdc_tcdm_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst_ni, clear_i;
   logic [N-1:0]      in_req_i, in_gnt_o, in_wen_i, in_r_valid_o;
   logic [N*AW-1:0]   in_add_i;
   logic [N*DW/8-1:0] in_be_i;
   logic [N*DW-1:0]   in_data_i;
   logic [DW-1:0]     in_r_data_o, tcdm_data_o, tcdm_r_data_i;
   logic              tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i, err_o;
   logic [AW-1:0]     tcdm_add_o;
   logic [DW/8-1:0]   tcdm_be_o;
`ifdef ROBERTS_MDC_TCDM_ARB_PERF_CNT_EN
   logic [31:0]       perf_gnt_cnt_o, perf_stall_cnt_o;
`endif

   int checks   = 0;
   int failures = 0;
   int exp_gnt[$];
   int exp_rsp[$];
   logic auto_rsp = 1'b0;
   logic gnt_seen = 1'b0;

   always #5 clk = ~clk;

   roberts_mdc_tcdm_rr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .MAX_OUT(4)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
      .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
      .in_be_i(in_be_i), .in_data_i(in_data_i), .in_r_data_o(in_r_data_o), .in_r_valid_o(in_r_valid_o),
      .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
      .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o), .tcdm_r_data_i(tcdm_r_data_i),
      .tcdm_r_valid_i(tcdm_r_valid_i), .err_o(err_o)
`ifdef ROBERTS_MDC_TCDM_ARB_PERF_CNT_EN
      , .perf_gnt_cnt_o(perf_gnt_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
   );

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] one;
      one = 1;
      return one << i;
   endfunction

   function automatic logic [AW-1:0] addr_of(input int i);
      return 32'h1000 + 32'(i) * 32'h10;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: scoreboard sampling at the falling edge, then drive after the rising edge.
   task automatic cyc();
      int e;
      @(negedge clk);
      gnt_seen = (in_gnt_o != '0);
      if (in_gnt_o != '0) begin
         if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(in_gnt_o), 64'd0);
         else begin
            e = exp_gnt.pop_front();
            chk("gnt", 64'(in_gnt_o), 64'(oh(e)));
            chk("gnt_add", 64'(tcdm_add_o), 64'(addr_of(e)));
            exp_rsp.push_back(e);
         end
      end
      if (in_r_valid_o != '0) begin
         if (exp_rsp.size() == 0) chk("rvalid_unexpected", 64'(in_r_valid_o), 64'd0);
         else begin
            e = exp_rsp.pop_front();
            chk("rvalid", 64'(in_r_valid_o), 64'(oh(e)));
            chk("rdata", 64'(in_r_data_o), 64'(tcdm_r_data_i));
         end
      end
      @(posedge clk);
      #1;
      tcdm_r_valid_i = auto_rsp & gnt_seen;
      tcdm_r_data_i  = $urandom;
   endtask

   task automatic chk_drained(input string tag);
      chk({tag, "_gnt_q"}, 64'(exp_gnt.size()), 64'd0);
      chk({tag, "_rsp_q"}, 64'(exp_rsp.size()), 64'd0);
   endtask

   initial begin
      rst_ni = 1'b0; clear_i = 1'b0; in_req_i = '1; tcdm_gnt_i = 1'b1;
      tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0;
      for (int i = 0; i < N; i++) begin
         in_add_i[i*AW +: AW]    = addr_of(i);
         in_data_i[i*DW +: DW]   = 32'hA0 + 32'(i);
         in_be_i[i*DW/8 +: DW/8] = 4'(i + 1);
         in_wen_i[i]             = i[0];
      end

      // Reset with every requester asserted
      repeat (2) @(posedge clk);
      #3;
      chk("rst_req", 64'(tcdm_req_o), 64'd0);
      chk("rst_gnt", 64'(in_gnt_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_rvalid", 64'(in_r_valid_o), 64'd0);
      in_req_i = '0;
      @(posedge clk); #1;
      rst_ni = 1'b1;

      // Round robin: all requesting, constant grant, responses one cycle later
      auto_rsp = 1'b1;
      exp_gnt = '{0, 1, 2, 3, 0};
      in_req_i = 4'b1111;
      repeat (5) cyc();
      in_req_i = '0;
      repeat (2) cyc();
      chk_drained("rr");

      // Lock: req0 stalled by TCDM, req1 arrives but must not steal the port
      tcdm_gnt_i = 1'b0;
      in_req_i = 4'b0001;
      #2;
      chk("lock_req", 64'(tcdm_req_o), 64'd1);
      chk("lock_add0", 64'(tcdm_add_o), 64'(addr_of(0)));
      cyc();
      in_req_i = 4'b0011;
      #2;
      chk("lock_add1", 64'(tcdm_add_o), 64'(addr_of(0)));
      chk("lock_nognt", 64'(in_gnt_o), 64'd0);
      cyc();
      #2;
      chk("lock_add2", 64'(tcdm_add_o), 64'(addr_of(0)));
      cyc();
      exp_gnt.push_back(0);
      tcdm_gnt_i = 1'b1;
      cyc();
      in_req_i = 4'b0010;
      exp_gnt.push_back(1);
      cyc();
      in_req_i = '0;
      repeat (2) cyc();
      chk_drained("lock");

      // Full: four grants without responses block the port until the cycle after a pop
      auto_rsp = 1'b0;
      in_req_i = 4'b0100;
      repeat (4) begin
         exp_gnt.push_back(2);
         cyc();
      end
      #2;
      chk("full_req", 64'(tcdm_req_o), 64'd0);
      chk("full_gnt", 64'(in_gnt_o), 64'd0);
      cyc();
      tcdm_r_valid_i = 1'b1;
      #2;
      chk("full_pop_same_cycle", 64'(tcdm_req_o), 64'd0);
      cyc();
      #2;
      chk("full_resume", 64'(tcdm_req_o), 64'd1);
      exp_gnt.push_back(2);
      cyc();
      in_req_i = '0;
      repeat (4) begin
         tcdm_r_valid_i = 1'b1;
         cyc();
      end
      cyc();
      chk_drained("full");
      chk("full_err", 64'(err_o), 64'd0);

      // Error: response with nothing outstanding is sticky until a clear
      tcdm_r_valid_i = 1'b1;
      #2;
      chk("err_drop", 64'(in_r_valid_o), 64'd0);
      cyc();
      #2;
      chk("err_set", 64'(err_o), 64'd1);
      cyc();
      #2;
      chk("err_sticky", 64'(err_o), 64'd1);
      clear_i = 1'b1;
      in_req_i = 4'b1111;
      #2;
      chk("clear_req", 64'(tcdm_req_o), 64'd0);
      chk("clear_gnt", 64'(in_gnt_o), 64'd0);
      cyc();
      clear_i = 1'b0;
      in_req_i = '0;
      #2;
      chk("clear_err", 64'(err_o), 64'd0);
`ifdef ROBERTS_MDC_TCDM_ARB_PERF_CNT_EN
      chk("clear_perf_gnt", 64'(perf_gnt_cnt_o), 64'd0);
      chk("clear_perf_stall", 64'(perf_stall_cnt_o), 64'd0);
`endif

      // Pointer returned to 0: requester 1 beats requester 3 (pointer was 3 before clear)
      auto_rsp = 1'b1;
      in_req_i = 4'b1010;
      exp_gnt.push_back(1);
      cyc();
      in_req_i = 4'b1000;
      exp_gnt.push_back(3);
      cyc();
      in_req_i = '0;
      repeat (2) cyc();
      chk_drained("clear_ptr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
